// File: rtl/brcmp_pkg.sv
// Shared types and helpers for the iterative branch comparator.
// Holds funct3 encodings, the FSM state type and the taken decode.
package brcmp_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } brcmp_state_t;

    function automatic logic brcmp_illegal(input logic [2:0] f3);
        return (f3 == 3'b010) || (f3 == 3'b011);
    endfunction

    function automatic logic brcmp_taken(
        input logic [2:0] f3,
        input logic       eq,
        input logic       lt
    );
        logic t;
        case (f3)
            F3_BEQ:           t = eq;
            F3_BNE:           t = !eq;
            F3_BLT, F3_BLTU:  t = lt;
            F3_BGE, F3_BGEU:  t = !lt;
            default:          t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/brcmp_slice.sv
// One CHUNK-wide magnitude compare step.
// The MSB slice of a signed compare flips both sign bits first.
module brcmp_slice #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             is_signed_msb,
    output logic             eq,
    output logic             lt
);

    logic [CHUNK-1:0] flip;
    logic [CHUNK-1:0] am;
    logic [CHUNK-1:0] bm;

    // Bias the sign bit so an unsigned compare yields the signed order.
    always_comb begin
        flip            = '0;
        flip[CHUNK-1]   = is_signed_msb;
        am              = a ^ flip;
        bm              = b ^ flip;
        eq              = (a == b);
        lt              = (am < bm);
    end

endmodule

// File: rtl/brcmp_iter.sv
// Multi-cycle branch comparator: MSB-first slices, early exit on
// the first differing slice, valid/ready on both sides.
module brcmp_iter
    import brcmp_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CHUNK = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [2:0]      funct3,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            br_taken,
    output logic            br_eq,
    output logic            br_lt,
    output logic            illegal
);

    localparam int NCHUNK = XLEN / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int NSLOT  = 1 << IW;

    brcmp_state_t state;
    brcmp_state_t state_nx;

    logic [IW-1:0]   idx;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [2:0]      f3;

    logic [CHUNK-1:0] s1 [NSLOT];
    logic [CHUNK-1:0] s2 [NSLOT];

    logic sl_signed;
    logic sl_eq;
    logic sl_lt;
    logic last;
    logic accept;
    logic decide;

    // Slot 0 is the most significant slice; pad slots never get selected.
    genvar g;
    generate
        for (g = 0; g < NSLOT; g++) begin : g_slot
            if (g < NCHUNK) begin : g_real
                assign s1[g] = op1[XLEN-1-g*CHUNK -: CHUNK];
                assign s2[g] = op2[XLEN-1-g*CHUNK -: CHUNK];
            end else begin : g_pad
                assign s1[g] = '0;
                assign s2[g] = '0;
            end
        end
    endgenerate

    assign sl_signed = (idx == '0) && !f3[1];

    brcmp_slice #(
        .CHUNK(CHUNK)
    ) u_slice (
        .a            (s1[idx]),
        .b            (s2[idx]),
        .is_signed_msb(sl_signed),
        .eq           (sl_eq),
        .lt           (sl_lt)
    );

    assign last      = (idx == IW'(NCHUNK - 1));
    assign in_ready  = (state == IDLE) && !rst && !flush;
    assign accept    = in_valid && in_ready;
    assign decide    = (state == BUSY) && (!sl_eq || last);
    assign out_valid = (state == DONE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic; flush beats any same-cycle output handshake.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept) state_nx = BUSY;
            BUSY: begin
                if (flush)       state_nx = IDLE;
                else if (decide) state_nx = DONE;
            end
            DONE: if (flush || out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture and slice index walk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op1 <= '0;
            op2 <= '0;
            f3  <= '0;
            idx <= '0;
        end else if (accept) begin
            op1 <= rs1;
            op2 <= rs2;
            f3  <= funct3;
            idx <= '0;
        end else if (state == BUSY && !flush && !decide) begin
            idx <= idx + 1'b1;
        end
    end

    // Result registers: loaded on the deciding edge, zero outside DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_eq    <= 1'b0;
            br_lt    <= 1'b0;
            br_taken <= 1'b0;
            illegal  <= 1'b0;
        end else if (state == BUSY && !flush && decide) begin
            br_eq    <= sl_eq;
            br_lt    <= !sl_eq && sl_lt;
            br_taken <= brcmp_taken(f3, sl_eq, !sl_eq && sl_lt);
            illegal  <= brcmp_illegal(f3);
        end else if (state_nx != DONE) begin
            br_eq    <= 1'b0;
            br_lt    <= 1'b0;
            br_taken <= 1'b0;
            illegal  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_brcmp_iter.sv
// Directed bench for brcmp_iter with a queue of expected results.
// Covers CHUNK=8 and the degenerate CHUNK=32 instance.
module tb_brcmp_iter;

    typedef struct {
        logic eq;
        logic lt;
        logic taken;
        logic ill;
        int   lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic [2:0]  funct3 = '0;
    logic        use32 = 1'b0;

    logic iv8, ir8, ov8, tk8, eq8, lt8, il8;
    logic iv32, ir32, ov32, tk32, eq32, lt32, il32;
    logic in_ready, out_valid, br_taken, br_eq, br_lt, illegal;

    int   checks = 0;
    int   failures = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;

    assign iv8  = in_valid && !use32;
    assign iv32 = in_valid && use32;

    assign in_ready  = use32 ? ir32 : ir8;
    assign out_valid = use32 ? ov32 : ov8;
    assign br_taken  = use32 ? tk32 : tk8;
    assign br_eq     = use32 ? eq32 : eq8;
    assign br_lt     = use32 ? lt32 : lt8;
    assign illegal   = use32 ? il32 : il8;

    brcmp_iter #(.XLEN(32), .CHUNK(8)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(iv8), .in_ready(ir8),
        .rs1(rs1), .rs2(rs2), .funct3(funct3),
        .out_valid(ov8), .out_ready(out_ready),
        .br_taken(tk8), .br_eq(eq8), .br_lt(lt8), .illegal(il8)
    );

    brcmp_iter #(.XLEN(32), .CHUNK(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(iv32), .in_ready(ir32),
        .rs1(rs1), .rs2(rs2), .funct3(funct3),
        .out_valid(ov32), .out_ready(out_ready),
        .br_taken(tk32), .br_eq(eq32), .br_lt(lt32), .illegal(il32)
    );

    function automatic exp_t model(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [2:0]  f,
        input int          chunk
    );
        exp_t        e;
        int          n;
        logic [31:0] m;
        logic [31:0] xa;
        logic [31:0] xb;
        bit          found;
        n     = 32 / chunk;
        m     = (chunk == 32) ? 32'hFFFF_FFFF : ((32'd1 << chunk) - 32'd1);
        e.ill = (f == 3'b010) || (f == 3'b011);
        e.eq  = (a == b);
        e.lt  = f[1] ? (a < b) : ($signed(a) < $signed(b));
        case (f)
            3'b000:         e.taken = e.eq;
            3'b001:         e.taken = !e.eq;
            3'b100, 3'b110: e.taken = e.lt;
            3'b101, 3'b111: e.taken = !e.lt;
            default:        e.taken = 1'b0;
        endcase
        e.lat = n;
        found = 1'b0;
        for (int i = 0; i < n; i++) begin
            xa = (a >> (32 - (i + 1) * chunk)) & m;
            xb = (b >> (32 - (i + 1) * chunk)) & m;
            if (!found && xa != xb) begin
                e.lat = i + 1;
                found = 1'b1;
            end
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] f, input bit push);
        rs1      = a;
        rs2      = b;
        funct3   = f;
        in_valid = 1'b1;
        chk("in_ready_at_issue", {31'd0, in_ready}, 32'd1);
        if (push) sbq.push_back(model(a, b, f, use32 ? 32 : 8));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag);
        int   cnt;
        exp_t e;
        cnt = 0;
        while (out_valid !== 1'b1 && cnt < 40) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        if (sbq.size() == 0) begin
            chk({tag, "_scoreboard"}, 32'd0, 32'd1);
        end else begin
            e = sbq.pop_front();
            chk({tag, "_latency"}, cnt, e.lat);
            chk({tag, "_eq"}, {31'd0, br_eq}, {31'd0, e.eq});
            chk({tag, "_lt"}, {31'd0, br_lt}, {31'd0, e.lt});
            chk({tag, "_taken"}, {31'd0, br_taken}, {31'd0, e.taken});
            chk({tag, "_illegal"}, {31'd0, illegal}, {31'd0, e.ill});
        end
    endtask

    task automatic finish_op(input string tag);
        @(posedge clk); #1;
        chk({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_outs_clear"},
            {28'd0, br_taken, br_eq, br_lt, illegal}, 32'd0);
    endtask

    task automatic run(input string tag, input logic [31:0] a,
                       input logic [31:0] b, input logic [2:0] f);
        start_op(a, b, f, 1'b1);
        wait_result(tag);
        finish_op(tag);
    endtask

    initial begin
        logic [3:0] held;
        int         seen;

        // Reset state
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_outs", {27'd0, out_valid, br_taken, br_eq, br_lt, illegal},
            32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // Main functions, CHUNK=8
        run("beq_equal", 32'h1234_5678, 32'h1234_5678, 3'b000);
        run("blt_neg_pos", 32'hFFFF_FFFF, 32'h0000_0001, 3'b100);
        run("bltu_big", 32'hFFFF_FFFF, 32'h0000_0001, 3'b110);
        run("bgeu_low", 32'h0000_0100, 32'h0000_0101, 3'b111);
        run("bge_mid", 32'h0012_0000, 32'h0011_FFFF, 3'b101);
        run("illegal_010", 32'h8000_0000, 32'h0000_0001, 3'b010);
        run("illegal_011", 32'h0000_0005, 32'h0000_0005, 3'b011);

        // Backpressure on a BNE result
        out_ready = 1'b0;
        start_op(32'h8000_0000, 32'h0000_0000, 3'b001, 1'b1);
        wait_result("bne_hold");
        held = {br_taken, br_eq, br_lt, illegal};
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
            chk("hold_taken", {31'd0, br_taken}, 32'd1);
            chk("hold_stable", {28'd0, br_taken, br_eq, br_lt, illegal},
                {28'd0, held});
        end
        out_ready = 1'b1;
        finish_op("bne_hold");
        run("after_hold", 32'h0000_0010, 32'h0000_0020, 3'b100);

        // Flush in the second BUSY cycle
        start_op(32'hCAFE_0000, 32'hCAFE_0000, 3'b000, 1'b0);
        @(posedge clk); #1;
        flush = 1'b1;
        #1;
        chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        #1;
        chk("flush_idle", {31'd0, in_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid === 1'b1) seen++;
            @(posedge clk); #1;
        end
        chk("flush_no_valid", seen, 0);

        // Flush while IDLE blocks acceptance
        rs1      = 32'h1;
        rs2      = 32'h2;
        funct3   = 3'b000;
        in_valid = 1'b1;
        flush    = 1'b1;
        #1;
        chk("idle_flush_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        #1;
        chk("idle_flush_not_taken", {31'd0, in_ready}, 32'd1);

        // Reset mid-BUSY
        start_op(32'h0000_0000, 32'h0000_0000, 3'b000, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rst_busy_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_busy_outs",
            {27'd0, out_valid, br_taken, br_eq, br_lt, illegal}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        run("post_rst", 32'h7FFF_FFFF, 32'h8000_0000, 3'b101);

        // Reset while DONE clears registered results asynchronously
        out_ready = 1'b0;
        start_op(32'h5555_0000, 32'h5555_0000, 3'b000, 1'b1);
        wait_result("rst_done");
        rst = 1'b1;
        #1;
        chk("rst_done_outs",
            {27'd0, out_valid, br_taken, br_eq, br_lt, illegal}, 32'd0);
        @(posedge clk); #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;

        // Degenerate CHUNK=32 instance
        use32 = 1'b1;
        #1;
        run("w32_beq", 32'h1234_5678, 32'h1234_5678, 3'b000);
        run("w32_blt", 32'hFFFF_FFFF, 32'h0000_0001, 3'b100);
        run("w32_bltu", 32'hFFFF_FFFF, 32'h0000_0001, 3'b110);
        run("w32_bgeu", 32'h0000_0100, 32'h0000_0101, 3'b111);
        run("w32_bne", 32'h8000_0000, 32'h0000_0000, 3'b001);
        run("w32_ill", 32'h0000_0003, 32'h0000_0009, 3'b010);

        chk("scoreboard_drained", sbq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
